conv2x_sched: RTL and testbench
===============================

CONV2X_SCHED -- requirements
Module: conv2x_sched

Interface
REQ-001 Parameter WIDTH, default 8: data word width, equal to the WIDTH of the downstream 2x-to-1x converter.
REQ-002 Parameter IFG, default 1, legal range 1..15: idle slots inserted between frames.
REQ-003 Port clk2x  input  1: the single clock, the 2x-rate clock.
REQ-004 Port rst2x  input  1: reset, asynchronous and active-high.
REQ-005 Port enable  input  1: allows new frames to start.
REQ-006 Port clr  input  1: synchronous clear of underrun and phcnt.
REQ-007 Port req  input  4: per-requester word-available flags.
REQ-008 Port reqdat  input  4*WIDTH: requester n drives bits [n*WIDTH +: WIDTH].
REQ-009 Port reqlast  input  4: marks the current word as the last word of the frame.
REQ-010 Port phaseout  input  1: phase-select indication from the converter.
REQ-011 Port gnt  output  4: one-cycle pulse; the word on reqdat[n] is accepted at this edge.
REQ-012 Port sync2x  output  1: frame-start marker to the converter.
REQ-013 Port data2x  output  WIDTH: word to the converter.
REQ-014 Port owner  output  2: index of the current frame owner.
REQ-015 Port busy  output  1: high in XFER or GAP.
REQ-016 Port underrun  output  1: sticky error flag.
REQ-017 Port phcnt  output  8: saturating count of phaseout edges.

Function
REQ-018 Slot toggle t: resets to 0 and flips every cycle; a word is accepted only on a cycle with t==0, and its output then occupies the two cycles after the edge (one clk1x period).
REQ-019 sync2x and data2x are registered and held stable for both cycles of a slot.
REQ-020 States: IDLE, XFER, GAP.
REQ-021 In IDLE, on a t==0 cycle with enable=1, |req=1 and no pending idle slot:
- the round-robin winner w is chosen, starting the search at ptr;
- gnt[w] pulses, owner<=w, sync2x<=1, data2x<=reqdat[w];
- the next state is XFER, or GAP if reqlast[w]=1.
REQ-022 In XFER, on each t==0 cycle:
- if req[owner]=1, accept the word: gnt pulses, sync2x<=0, data2x<=reqdat[owner];
- if req[owner]=0 (underrun), data2x<=0, sync2x<=0, underrun<=1, and the next state is GAP.
REQ-023 A word accepted with reqlast[owner]=1 ends the frame: the next state is GAP and ptr<=owner+1 (mod 4); ptr also advances on underrun.
REQ-024 GAP lasts IFG slots with sync2x=0 and data2x=0, then returns to IDLE.
REQ-025 Phase edges:
- a phaseout edge is detected by comparison with its registered copy;
- each edge increments phcnt, which saturates at 255;
- an edge seen in IDLE or GAP sets a pending flag, which inserts one extra idle slot before the next frame start and then clears;
- an edge seen in XFER only counts.
REQ-026 enable=0 never truncates a frame; it only blocks the IDLE->XFER transition.
REQ-027 clr=1 zeroes underrun and phcnt at the next edge; a simultaneous set or increment loses to clr.
REQ-028 Requests that are not owned are ignored, and gnt is never asserted for more than one bit at a time.
REQ-029 Latency: gnt edge to sync2x/data2x valid is 0 cycles (the outputs update at the same edge).

Reset
REQ-030 Reset values:
- state=IDLE, t=0, ptr=0, pending=0;
- gnt=0, sync2x=0, data2x=0, owner=0, busy=0, underrun=0, phcnt=0;
- the registered phaseout copy = 0.
REQ-031 Reset asserted mid-frame abandons the frame immediately; after release, arbitration restarts from requester 0.

Structure
REQ-032 A shared package holds the state encoding (IDLE, XFER, GAP), NREQ=4, the phcnt width (8) and the IFG legal range.
REQ-033 One sub-module, rrarb4, holds the combinational 4-way round-robin winner select from req and ptr.

Verification
REQ-034 Single frame: req[2]=1 with three words A1,A2,A3 (reqlast on A3) -> gnt[2] pulses on three consecutive t==0 edges; sync2x is high only for the A1 slot; data2x = A1,A2,A3, each for 2 cycles; then 1 idle slot.
REQ-035 Round-robin: req=4'b1111 with one-word frames, starting from ptr=0 -> owner sequence 0,1,2,3,0.
REQ-036 Underrun: req[1] drops after word 2 of a 4-word frame -> underrun=1, data2x=0, state GAP; clr=1 -> underrun=0.
REQ-037 Phase event: toggle phaseout during GAP with IFG=1 -> phcnt=1; the next frame starts 2 slots after the frame end, not 1.
REQ-038 Saturation and reset: 300 phaseout toggles -> phcnt=255; rst2x pulsed mid-frame -> all outputs at reset values; the next frame is granted to the lowest requesting index.

Source files
------------

// File: rtl/conv2x_sched_pkg.sv
// conv2x_sched_pkg -- shared definitions for the 2x-rate frame scheduler.
//   state_t     : scheduler FSM encoding (IDLE, XFER, GAP)
//   NREQ        : number of requesters
//   PHCNT_W     : width of the phase-edge counter
//   IFG_MIN/MAX : legal range of the inter-frame gap parameter
//   helpers     : round-robin pointer increment, one-hot grant, IFG clamp
package conv2x_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int NREQ    = 4;
  localparam int PHCNT_W = 8;
  localparam int IFG_MIN = 1;
  localparam int IFG_MAX = 15;

  localparam logic [PHCNT_W-1:0] PHCNT_MAX = {PHCNT_W{1'b1}};
  localparam logic [PHCNT_W-1:0] PHCNT_ONE = {{(PHCNT_W-1){1'b0}}, 1'b1};

  // Next round-robin start position; wraps naturally in two bits.
  function automatic logic [1:0] ptr_inc(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

  // One-hot grant vector for a requester index.
  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Keeps an out-of-range gap setting inside the supported range.
  function automatic int ifg_legal(input int ifg);
    if (ifg < IFG_MIN) begin
      return IFG_MIN;
    end else if (ifg > IFG_MAX) begin
      return IFG_MAX;
    end else begin
      return ifg;
    end
  endfunction

endpackage

// File: rtl/conv2x_sched_rrarb4.sv
// rrarb4 -- combinational 4-way round-robin winner select.
//   req    : request flags, one per requester
//   ptr    : index at which the search starts (highest priority)
//   valid  : at least one request is present
//   winner : first requesting index found at or after ptr (wrapping)
module rrarb4
  import conv2x_sched_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic            valid,
  output logic [1:0]      winner
);

  logic       found_s;
  logic [1:0] idx_s;

  // Scan ptr, ptr+1, ... (mod 4) and keep the first requester seen.
  always_comb begin
    valid   = |req;
    winner  = ptr;
    found_s = 1'b0;
    idx_s   = ptr;
    for (int i = 0; i < NREQ; i++) begin
      idx_s = ptr + 2'(i);
      if (!found_s && req[idx_s]) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/conv2x_sched.sv
// conv2x_sched -- frame scheduler feeding a 2x-to-1x converter.
// Runs entirely on the 2x clock; a slot toggle splits time into two-cycle
// slots (one 1x period). Words are accepted only at the edge closing a
// t==0 cycle, and the registered outputs then hold for the whole slot.
// Ports:
//   clk2x    : 2x-rate clock
//   rst2x    : asynchronous active-high reset
//   enable   : allows new frames to start (never truncates one)
//   clr      : synchronous clear of underrun and phcnt
//   req      : per-requester word-available flags
//   reqdat   : requester n data in bits [n*WIDTH +: WIDTH]
//   reqlast  : current word of requester n is the last of its frame
//   phaseout : phase-select indication from the converter
//   gnt      : one-cycle pulse, the owner's word was taken at this edge
//   sync2x   : frame-start marker, held for the first slot of a frame
//   data2x   : word to the converter, held for a full slot
//   owner    : index of the current frame owner
//   busy     : high while in XFER or GAP
//   underrun : sticky error, owner ran dry mid-frame
//   phcnt    : saturating count of phaseout edges
module conv2x_sched
  import conv2x_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IFG   = 1
) (
  input  logic                clk2x,
  input  logic                rst2x,
  input  logic                enable,
  input  logic                clr,
  input  logic [NREQ-1:0]     req,
  input  logic [4*WIDTH-1:0]  reqdat,
  input  logic [NREQ-1:0]     reqlast,
  input  logic                phaseout,
  output logic [NREQ-1:0]     gnt,
  output logic                sync2x,
  output logic [WIDTH-1:0]    data2x,
  output logic [1:0]          owner,
  output logic                busy,
  output logic                underrun,
  output logic [PHCNT_W-1:0]  phcnt
);

  localparam int         IFG_C    = ifg_legal(IFG);
  localparam logic [3:0] GAP_LAST = 4'(IFG_C - 1);

  state_t     state_r;
  logic       t_r;
  logic [1:0] ptr_r;
  logic       pending_r;
  logic [3:0] gapcnt_r;
  logic       ph_r;

  logic             slot_s;
  logic             ph_edge_s;
  logic             arb_valid_s;
  logic [1:0]       arb_win_s;
  logic             own_req_s;
  logic             own_last_s;
  logic [WIDTH-1:0] own_dat_s;
  logic             win_last_s;
  logic [WIDTH-1:0] win_dat_s;
  logic             underrun_set_s;

  rrarb4 u_arb (
    .req    (req),
    .ptr    (ptr_r),
    .valid  (arb_valid_s),
    .winner (arb_win_s)
  );

  // Select owner/winner lanes and detect phase edges and underrun.
  always_comb begin
    slot_s         = (t_r == 1'b0);
    ph_edge_s      = phaseout ^ ph_r;
    own_req_s      = req[owner];
    own_last_s     = reqlast[owner];
    own_dat_s      = reqdat[int'(owner)*WIDTH +: WIDTH];
    win_last_s     = reqlast[arb_win_s];
    win_dat_s      = reqdat[int'(arb_win_s)*WIDTH +: WIDTH];
    underrun_set_s = slot_s && (state_r == ST_XFER) && !own_req_s;
  end

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk2x or posedge rst2x) begin
    if (rst2x) begin
      state_r   <= ST_IDLE;
      t_r       <= 1'b0;
      ptr_r     <= 2'd0;
      pending_r <= 1'b0;
      gapcnt_r  <= 4'd0;
      ph_r      <= 1'b0;
      gnt       <= {NREQ{1'b0}};
      sync2x    <= 1'b0;
      data2x    <= {WIDTH{1'b0}};
      owner     <= 2'd0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
      phcnt     <= {PHCNT_W{1'b0}};
    end else begin
      t_r  <= ~t_r;
      ph_r <= phaseout;
      gnt  <= {NREQ{1'b0}};

      // clr dominates any simultaneous increment.
      if (clr) begin
        phcnt <= {PHCNT_W{1'b0}};
      end else if (ph_edge_s && (phcnt != PHCNT_MAX)) begin
        phcnt <= phcnt + PHCNT_ONE;
      end else begin
        phcnt <= phcnt;
      end

      if (clr) begin
        underrun <= 1'b0;
      end else if (underrun_set_s) begin
        underrun <= 1'b1;
      end else begin
        underrun <= underrun;
      end

      // A new edge outside XFER re-arms the flag even on the slot that
      // would otherwise consume it.
      if (ph_edge_s && (state_r != ST_XFER)) begin
        pending_r <= 1'b1;
      end else if (slot_s && (state_r == ST_IDLE) && pending_r) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end

      if (slot_s) begin
        case (state_r)
          ST_IDLE: begin
            if (pending_r) begin
              // Extra idle slot requested by a phase edge.
              sync2x <= 1'b0;
              data2x <= {WIDTH{1'b0}};
            end else if (enable && arb_valid_s) begin
              gnt      <= onehot4(arb_win_s);
              owner    <= arb_win_s;
              sync2x   <= 1'b1;
              data2x   <= win_dat_s;
              busy     <= 1'b1;
              gapcnt_r <= 4'd0;
              if (win_last_s) begin
                state_r <= ST_GAP;
                ptr_r   <= ptr_inc(arb_win_s);
              end else begin
                state_r <= ST_XFER;
              end
            end else begin
              sync2x <= 1'b0;
              data2x <= {WIDTH{1'b0}};
            end
          end
          ST_XFER: begin
            sync2x <= 1'b0;
            if (own_req_s) begin
              gnt    <= onehot4(owner);
              data2x <= own_dat_s;
              if (own_last_s) begin
                state_r  <= ST_GAP;
                ptr_r    <= ptr_inc(owner);
                gapcnt_r <= 4'd0;
              end else begin
                state_r <= ST_XFER;
              end
            end else begin
              // Owner ran dry: abandon the frame and move the pointer on.
              data2x   <= {WIDTH{1'b0}};
              state_r  <= ST_GAP;
              ptr_r    <= ptr_inc(owner);
              gapcnt_r <= 4'd0;
            end
          end
          ST_GAP: begin
            sync2x <= 1'b0;
            data2x <= {WIDTH{1'b0}};
            if (gapcnt_r == GAP_LAST) begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end else begin
              gapcnt_r <= gapcnt_r + 4'd1;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            sync2x  <= 1'b0;
            data2x  <= {WIDTH{1'b0}};
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_conv2x_sched.sv
// tb_conv2x_sched -- directed self-checking bench for conv2x_sched
// (WIDTH=8, IFG=1). Each task positions itself on a slot boundary
// (just after the t==1 edge) and steps one clock per tick.
module tb_conv2x_sched;

  logic        clk2x;
  logic        rst2x;
  logic        enable;
  logic        clr;
  logic [3:0]  req;
  logic [31:0] reqdat;
  logic [3:0]  reqlast;
  logic        phaseout;
  logic [3:0]  gnt;
  logic        sync2x;
  logic [7:0]  data2x;
  logic [1:0]  owner;
  logic        busy;
  logic        underrun;
  logic [7:0]  phcnt;

  int checks = 0;
  int errors = 0;

  conv2x_sched #(.WIDTH(8), .IFG(1)) dut (
    .clk2x    (clk2x),
    .rst2x    (rst2x),
    .enable   (enable),
    .clr      (clr),
    .req      (req),
    .reqdat   (reqdat),
    .reqlast  (reqlast),
    .phaseout (phaseout),
    .gnt      (gnt),
    .sync2x   (sync2x),
    .data2x   (data2x),
    .owner    (owner),
    .busy     (busy),
    .underrun (underrun),
    .phcnt    (phcnt)
  );

  initial clk2x = 1'b0;
  always #5 clk2x = ~clk2x;

  task automatic tick();
    @(posedge clk2x);
    #1;
  endtask

  // Leaves the DUT out of reset with t==0, so the next edge accepts.
  task automatic do_reset();
    rst2x    = 1'b1;
    enable   = 1'b1;
    clr      = 1'b0;
    req      = 4'b0000;
    reqdat   = 32'h0;
    reqlast  = 4'b0000;
    phaseout = 1'b0;
    tick();
    tick();
    rst2x = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt, sync2x, data2x, owner} !== {4'b0000, 1'b0, 8'h00, 2'd0}) begin
      errors++;
      $display("FAIL reset_dp got gnt=%b sync=%b data=%h owner=%0d exp 0", gnt, sync2x, data2x, owner);
    end
    checks++;
    if ({busy, underrun} !== 2'b00) begin
      errors++;
      $display("FAIL reset_flags got busy=%b underrun=%b exp 0 0", busy, underrun);
    end
    checks++;
    if (phcnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_phcnt got %0d exp 0", phcnt);
    end
  endtask

  task automatic test_single_frame();
    do_reset();
    req = 4'b0100; reqdat[23:16] = 8'hA1;
    tick();
    checks++;
    if ({gnt, sync2x, data2x, owner, busy} !== {4'b0100, 1'b1, 8'hA1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL single_a1 got gnt=%b sync=%b data=%h owner=%0d busy=%b exp 0100 1 a1 2 1", gnt, sync2x, data2x, owner, busy);
    end
    reqdat[23:16] = 8'hA2;
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0000, 1'b1, 8'hA1}) begin
      errors++;
      $display("FAIL single_a1_hold got gnt=%b sync=%b data=%h exp 0000 1 a1", gnt, sync2x, data2x);
    end
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0100, 1'b0, 8'hA2}) begin
      errors++;
      $display("FAIL single_a2 got gnt=%b sync=%b data=%h exp 0100 0 a2", gnt, sync2x, data2x);
    end
    reqdat[23:16] = 8'hA3; reqlast = 4'b0100;
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0000, 1'b0, 8'hA2}) begin
      errors++;
      $display("FAIL single_a2_hold got gnt=%b sync=%b data=%h exp 0000 0 a2", gnt, sync2x, data2x);
    end
    tick();
    checks++;
    if ({gnt, sync2x, data2x, busy} !== {4'b0100, 1'b0, 8'hA3, 1'b1}) begin
      errors++;
      $display("FAIL single_a3 got gnt=%b sync=%b data=%h busy=%b exp 0100 0 a3 1", gnt, sync2x, data2x, busy);
    end
    req = 4'b0000; reqlast = 4'b0000;
    tick();
    checks++;
    if ({gnt, data2x} !== {4'b0000, 8'hA3}) begin
      errors++;
      $display("FAIL single_a3_hold got gnt=%b data=%h exp 0000 a3", gnt, data2x);
    end
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_gap got gnt=%b sync=%b data=%h exp 0000 0 00", gnt, sync2x, data2x);
    end
    tick();
    tick();
    checks++;
    if ({gnt, busy, data2x} !== {4'b0000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL single_idle got gnt=%b busy=%b data=%h exp 0000 0 00", gnt, busy, data2x);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] w;
    logic [7:0] exp_d;
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111; reqlast = 4'b1111; reqdat = 32'h44332211;
    for (int k = 0; k < 5; k++) begin
      w     = 2'(k % 4);
      exp_d = reqdat[int'(w)*8 +: 8];
      exp_g = 4'b0001 << w;
      tick();
      checks++;
      if ({gnt, sync2x, data2x, owner} !== {exp_g, 1'b1, exp_d, w}) begin
        errors++;
        $display("FAIL rr_frame%0d got gnt=%b sync=%b data=%h owner=%0d exp %b 1 %h %0d", k, gnt, sync2x, data2x, owner, exp_g, exp_d, w);
      end
      tick();
      tick();
      tick();
    end
    req = 4'b0000; reqlast = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_underrun();
    do_reset();
    req = 4'b0010; reqdat[15:8] = 8'hB1;
    tick();
    checks++;
    if ({gnt, owner, sync2x, data2x} !== {4'b0010, 2'd1, 1'b1, 8'hB1}) begin
      errors++;
      $display("FAIL ur_b1 got gnt=%b owner=%0d sync=%b data=%h exp 0010 1 1 b1", gnt, owner, sync2x, data2x);
    end
    tick();
    reqdat[15:8] = 8'hB2;
    tick();
    checks++;
    if ({gnt, data2x} !== {4'b0010, 8'hB2}) begin
      errors++;
      $display("FAIL ur_b2 got gnt=%b data=%h exp 0010 b2", gnt, data2x);
    end
    req = 4'b0000;
    tick();
    tick();
    checks++;
    if ({underrun, data2x, sync2x, gnt, busy} !== {1'b1, 8'h00, 1'b0, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL ur_event got underrun=%b data=%h sync=%b gnt=%b busy=%b exp 1 00 0 0000 1", underrun, data2x, sync2x, gnt, busy);
    end
    repeat (4) tick();
    checks++;
    if ({underrun, busy} !== 2'b10) begin
      errors++;
      $display("FAIL ur_sticky got underrun=%b busy=%b exp 1 0", underrun, busy);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL ur_clr got %b exp 0", underrun);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0; req = 4'b0001; reqdat[7:0] = 8'h51;
    repeat (4) tick();
    checks++;
    if ({gnt, busy, sync2x} !== {4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL en_block got gnt=%b busy=%b sync=%b exp 0000 0 0", gnt, busy, sync2x);
    end
    enable = 1'b1;
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0001, 1'b1, 8'h51}) begin
      errors++;
      $display("FAIL en_start got gnt=%b sync=%b data=%h exp 0001 1 51", gnt, sync2x, data2x);
    end
    enable = 1'b0; reqdat[7:0] = 8'h52;
    tick();
    tick();
    checks++;
    if ({gnt, data2x, busy} !== {4'b0001, 8'h52, 1'b1}) begin
      errors++;
      $display("FAIL en_no_trunc got gnt=%b data=%h busy=%b exp 0001 52 1", gnt, data2x, busy);
    end
    reqdat[7:0] = 8'h53; reqlast = 4'b0001;
    tick();
    tick();
    checks++;
    if ({gnt, data2x} !== {4'b0001, 8'h53}) begin
      errors++;
      $display("FAIL en_last got gnt=%b data=%h exp 0001 53", gnt, data2x);
    end
    req = 4'b0000; reqlast = 4'b0000; enable = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_phase_event();
    do_reset();
    req = 4'b0001; reqlast = 4'b0001; reqdat[7:0] = 8'hC1;
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0001, 1'b1, 8'hC1}) begin
      errors++;
      $display("FAIL ph_first got gnt=%b sync=%b data=%h exp 0001 1 c1", gnt, sync2x, data2x);
    end
    phaseout = 1'b1;
    tick();
    checks++;
    if (phcnt !== 8'd1) begin
      errors++;
      $display("FAIL ph_count got %0d exp 1", phcnt);
    end
    tick();
    tick();
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL ph_extra_idle got gnt=%b sync=%b data=%h exp 0000 0 00", gnt, sync2x, data2x);
    end
    tick();
    tick();
    checks++;
    if ({gnt, sync2x, data2x} !== {4'b0001, 1'b1, 8'hC1}) begin
      errors++;
      $display("FAIL ph_restart got gnt=%b sync=%b data=%h exp 0001 1 c1", gnt, sync2x, data2x);
    end
    req = 4'b0000; reqlast = 4'b0000;
    repeat (4) tick();
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      phaseout = ~phaseout;
      tick();
    end
    checks++;
    if (phcnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_phcnt got %0d exp 255", phcnt);
    end
    clr = 1'b1;
    phaseout = ~phaseout;
    tick();
    clr = 1'b0;
    checks++;
    if (phcnt !== 8'd0) begin
      errors++;
      $display("FAIL sat_clr_wins got %0d exp 0", phcnt);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    req = 4'b1000; reqdat[31:24] = 8'hD1;
    tick();
    checks++;
    if ({gnt, owner} !== {4'b1000, 2'd3}) begin
      errors++;
      $display("FAIL mid_d1 got gnt=%b owner=%0d exp 1000 3", gnt, owner);
    end
    tick();
    reqdat[31:24] = 8'hD2; req = 4'b1010; reqdat[15:8] = 8'hE1;
    tick();
    checks++;
    if ({gnt, owner, data2x} !== {4'b1000, 2'd3, 8'hD2}) begin
      errors++;
      $display("FAIL mid_d2_owned got gnt=%b owner=%0d data=%h exp 1000 3 d2", gnt, owner, data2x);
    end
    rst2x = 1'b1;
    #1;
    checks++;
    if ({gnt, sync2x, data2x, owner, busy, underrun, phcnt} !== 18'd0) begin
      errors++;
      $display("FAIL mid_async_rst got gnt=%b sync=%b data=%h owner=%0d busy=%b ur=%b phcnt=%0d exp all 0", gnt, sync2x, data2x, owner, busy, underrun, phcnt);
    end
    tick();
    rst2x = 1'b0;
    tick();
    checks++;
    if ({gnt, owner, sync2x, data2x} !== {4'b0010, 2'd1, 1'b1, 8'hE1}) begin
      errors++;
      $display("FAIL mid_restart got gnt=%b owner=%0d sync=%b data=%h exp 0010 1 1 e1", gnt, owner, sync2x, data2x);
    end
  endtask

  initial begin
    rst2x    = 1'b1;
    enable   = 1'b0;
    clr      = 1'b0;
    req      = 4'b0000;
    reqdat   = 32'h0;
    reqlast  = 4'b0000;
    phaseout = 1'b0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_enable();
    test_phase_event();
    test_saturate();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
